// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control unit.
// Holds the FSM state encoding, the opcodes and the ALU operation codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXEC_ALU  = 3'd2,
    EXEC_ADDR = 3'd3,
    MEM       = 3'd4,
    WB        = 3'd5,
    TRAP      = 3'd6
  } state_e;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_L = 7'b0000011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_S = 7'b0100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation and operand-B select decode from the raw instruction.
// Independent of FSM state, so the datapath sees a stable op for the whole instruction.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] instrCode,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instrCode[6:0];
  assign funct3 = instrCode[14:12];

  always_comb begin
    aluControl   = ALU_ADD;
    aluSrcMuxSel = 1'b0;
    case (opcode)
      OPC_R: aluControl = {instrCode[30], funct3};
      OPC_I: begin
        aluSrcMuxSel = 1'b1;
        // bit 30 is an immediate bit for every I op except the shift-right pair
        aluControl   = (funct3 == 3'b101) ? {instrCode[30], funct3} : {1'b0, funct3};
      end
      OPC_L, OPC_S: begin
        aluSrcMuxSel = 1'b1;
        aluControl   = ALU_ADD;
      end
      default: begin
        aluControl   = ALU_ADD;
        aluSrcMuxSel = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences one instruction at a time and owns
// the load/store bus handshake; pcEn pulses exactly once per retired instruction.
//
// state     | meaning
// FETCH     | instruction word settling from instruction memory
// DECODE    | opcode classification
// EXEC_ALU  | R/I result written back, PC advances
// EXEC_ADDR | load/store effective address computed
// MEM       | bus transaction held until busReady
// WB        | load data written back, PC advances
// TRAP      | unsupported opcode, frozen until reset
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic        RFWDSrcMuxSel,
  output logic        pcEn,
  output logic        busReq,
  output logic        busWe,
  output logic        illegalInstr
);

  state_e state_q, state_d;

  logic is_r, is_i, is_l, is_s;

  assign is_r = (instrCode[6:0] == OPC_R);
  assign is_i = (instrCode[6:0] == OPC_I);
  assign is_l = (instrCode[6:0] == OPC_L);
  assign is_s = (instrCode[6:0] == OPC_S);

  alu_decoder u_alu_decoder (
    .instrCode    (instrCode),
    .aluControl   (aluControl),
    .aluSrcMuxSel (aluSrcMuxSel)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    regFileWe     = 1'b0;
    RFWDSrcMuxSel = 1'b0;
    pcEn          = 1'b0;
    busReq        = 1'b0;
    busWe         = 1'b0;
    illegalInstr  = 1'b0;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        if (is_r || is_i)      state_d = EXEC_ALU;
        else if (is_l || is_s) state_d = EXEC_ADDR;
        else                   state_d = TRAP;
      end
      EXEC_ALU: begin
        regFileWe = 1'b1;
        pcEn      = 1'b1;
        state_d   = FETCH;
      end
      EXEC_ADDR: state_d = MEM;
      MEM: begin
        busReq = 1'b1;
        busWe  = is_s;
        // stores retire on the ready cycle itself; loads still need WB
        if (busReady) begin
          if (is_s) begin
            pcEn    = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 1'b1;
        pcEn          = 1'b1;
        state_d       = FETCH;
      end
      TRAP: illegalInstr = 1'b1;
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected output
// vectors are queued with the stimulus and compared at the falling edge.
module tb_multicycle_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;
  logic        regFileWe;
  logic [3:0]  aluControl;
  logic        aluSrcMuxSel;
  logic        RFWDSrcMuxSel;
  logic        pcEn;
  logic        busReq;
  logic        busWe;
  logic        illegalInstr;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [10:0] exp_q[$];
  logic [1:0]  drv_q[$];
  string       tag_q[$];

  multicycle_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .instrCode     (instrCode),
    .busReady      (busReady),
    .regFileWe     (regFileWe),
    .aluControl    (aluControl),
    .aluSrcMuxSel  (aluSrcMuxSel),
    .RFWDSrcMuxSel (RFWDSrcMuxSel),
    .pcEn          (pcEn),
    .busReq        (busReq),
    .busWe         (busWe),
    .illegalInstr  (illegalInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {aluControl, aluSrcMuxSel, regFileWe, pcEn, busReq, busWe, RFWDSrcMuxSel, illegalInstr}
  function automatic logic [10:0] ev(input logic [3:0] alu, input logic src,
                                     input logic we, input logic pc, input logic req,
                                     input logic bwe, input logic rfwd, input logic ill);
    return {alu, src, we, pc, req, bwe, rfwd, ill};
  endfunction

  function automatic logic [10:0] observed();
    return {aluControl, aluSrcMuxSel, regFileWe, pcEn, busReq, busWe, RFWDSrcMuxSel, illegalInstr};
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %b, want %b (alu,src,we,pc,req,bwe,rfwd,ill)", tag, obs, exp);
    end
  endtask

  task automatic sched(input logic rst, input logic rdy, input logic [10:0] e, input string tag);
    drv_q.push_back({rst, rdy});
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Drives one queued cycle per clock; called right after a rising edge (+#1).
  task automatic run();
    logic [1:0] d;
    while (drv_q.size() > 0) begin
      d = drv_q.pop_front();
      reset    = d[1];
      busReady = d[0];
      @(negedge clk);
      check(tag_q.pop_front(), observed(), exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  // kind: 0 = R/I, 1 = store, 2 = load. n = MEM cycles with busReady low.
  task automatic instr(input string name, input logic [31:0] code, input int kind,
                       input int n, input logic idle_rdy, input logic [3:0] alu,
                       input logic src);
    instrCode = code;
    sched(1'b0, idle_rdy, ev(alu, src, 0, 0, 0, 0, 0, 0), {name, ":fetch"});
    sched(1'b0, idle_rdy, ev(alu, src, 0, 0, 0, 0, 0, 0), {name, ":decode"});
    if (kind == 0) begin
      sched(1'b0, idle_rdy, ev(alu, src, 1, 1, 0, 0, 0, 0), {name, ":exec"});
    end else begin
      sched(1'b0, idle_rdy, ev(alu, src, 0, 0, 0, 0, 0, 0), {name, ":addr"});
      for (int i = 0; i < n; i++)
        sched(1'b0, 1'b0, ev(alu, src, 0, 0, 1, kind == 1, 0, 0), {name, ":mem_wait"});
      sched(1'b0, 1'b1, ev(alu, src, 0, kind == 1, 1, kind == 1, 0, 0), {name, ":mem_ready"});
      if (kind == 2)
        sched(1'b0, idle_rdy, ev(alu, src, 1, 1, 0, 0, 1, 0), {name, ":wb"});
    end
    run();
  endtask

  initial begin
    reset     = 1'b1;
    busReady  = 1'b0;
    instrCode = 32'h002081B3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", observed(), ev(4'b0000, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;

    instr("add",   32'h002081B3, 0, 0, 1'b0, 4'b0000, 1'b0);
    instr("srai",  32'h40335293, 0, 0, 1'b0, 4'b1101, 1'b1);
    instr("sub",   32'h40208233, 0, 0, 1'b1, 4'b1000, 1'b0);
    instr("addi30",32'h40000093, 0, 0, 1'b0, 4'b0000, 1'b1);
    instr("sw",    32'h0020A423, 1, 2, 1'b1, 4'b0000, 1'b1);
    instr("lw",    32'h0040A203, 2, 0, 1'b1, 4'b0000, 1'b1);
    instr("lw_w3", 32'h0040A203, 2, 3, 1'b0, 4'b0000, 1'b1);
    instr("sw_w0", 32'h0020A423, 1, 0, 1'b0, 4'b0000, 1'b1);

    // Illegal opcode: trap, stay there with busReady toggling, then a one-cycle reset.
    instrCode = 32'h0000006F;
    sched(1'b0, 1'b0, ev(4'b0000, 0, 0, 0, 0, 0, 0, 0), "ill:fetch");
    sched(1'b0, 1'b1, ev(4'b0000, 0, 0, 0, 0, 0, 0, 0), "ill:decode");
    for (int i = 0; i < 22; i++)
      sched(1'b0, 1'($urandom_range(0, 1)), ev(4'b0000, 0, 0, 0, 0, 0, 0, 1), "ill:trap");
    sched(1'b1, 1'b0, ev(4'b0000, 0, 0, 0, 0, 0, 0, 1), "ill:reset_cycle");
    run();
    instr("add_after_trap", 32'h002081B3, 0, 0, 1'b0, 4'b0000, 1'b0);

    // Reset during the MEM wait of a load: restart from FETCH, no WB for the abandoned load.
    instrCode = 32'h0040A203;
    sched(1'b0, 1'b0, ev(4'b0000, 1, 0, 0, 0, 0, 0, 0), "lwrst:fetch");
    sched(1'b0, 1'b0, ev(4'b0000, 1, 0, 0, 0, 0, 0, 0), "lwrst:decode");
    sched(1'b0, 1'b0, ev(4'b0000, 1, 0, 0, 0, 0, 0, 0), "lwrst:addr");
    sched(1'b0, 1'b0, ev(4'b0000, 1, 0, 0, 1, 0, 0, 0), "lwrst:mem_wait");
    sched(1'b1, 1'b0, ev(4'b0000, 1, 0, 0, 1, 0, 0, 0), "lwrst:mem_reset");
    run();
    instr("lw_after_rst", 32'h0040A203, 2, 1, 1'b0, 4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
